// File: rtl/decoder_2x4_strobe_if.sv
// decoder_2x4_strobe_if: code input handshake plus strobed one-hot output.
// master drives codes in and watches the pattern; slave is the decoder.
interface decoder_2x4_strobe_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       done;
    logic       busy;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  out_onehot,
        input  out_valid,
        input  done,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output out_onehot,
        output out_valid,
        output done,
        output busy
    );
endinterface

// File: rtl/decoder_2x4_strobe.sv
// decoder_2x4_strobe: 2-entry code FIFO feeding an IDLE/SHOW/GAP strobe FSM.
// Each code is shown as a one-hot pattern for HOLD cycles, then GAP blanks.
module decoder_2x4_strobe #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    decoder_2x4_strobe_if.slave  bus
);

    localparam logic [7:0] HOLD_LD = 8'(HOLD - 32'd1);
    localparam logic [7:0] GAP_LD  = 8'(GAP - 32'd1);
    localparam bit         GAP_EN  = (GAP != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_t;

    // Fixed mapping: highest code lights the lowest line.
    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (1'b1)
            (code == 2'd3): oh = 4'b0001;
            (code == 2'd2): oh = 4'b0010;
            (code == 2'd1): oh = 4'b0100;
            (code == 2'd0): oh = 4'b1000;
            default:        oh = 4'b0000;
        endcase
        return oh;
    endfunction

    logic [1:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       in_ready_r;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic [1:0] head;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [3:0] onehot_q;
    logic [3:0] onehot_d;

    // in_ready comes from the count register only, so a same-cycle pop
    // from a full FIFO never opens the input early.
    assign in_ready_r = (count != 2'd2);
    assign fifo_empty = (count == 2'd0);
    assign push       = bus.in_valid && in_ready_r;
    assign head       = mem[rd_ptr];

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= 2'd0;
            mem[1] <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.in_code;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Strobe FSM state, down-counter and registered pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            onehot_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
        end
    end

    // Next state: load on pop, count down, blank in GAP and IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        pop      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                onehot_d = 4'b0000;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    onehot_d = decode(head);
                    cnt_d    = HOLD_LD;
                    state_d  = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (GAP_EN) begin
                    state_d  = S_GAP;
                    cnt_d    = GAP_LD;
                    onehot_d = 4'b0000;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    onehot_d = decode(head);
                    cnt_d    = HOLD_LD;
                end else begin
                    state_d  = S_IDLE;
                    onehot_d = 4'b0000;
                end
            end
            S_GAP: begin
                onehot_d = 4'b0000;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    onehot_d = decode(head);
                    cnt_d    = HOLD_LD;
                    state_d  = S_SHOW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = 8'd0;
                onehot_d = 4'b0000;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_onehot = onehot_q;
    assign bus.out_valid  = (state_q == S_SHOW);
    assign bus.done       = (state_q == S_SHOW) && (cnt_q == 8'd0);
    assign bus.busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_decoder_2x4_strobe.sv
// tb_decoder_2x4_strobe: directed checks on two decoder instances,
// one with HOLD=4/GAP=1 and one with HOLD=1/GAP=0.
module tb_decoder_2x4_strobe;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [3:0] capq [$];

    decoder_2x4_strobe_if ifa ();
    decoder_2x4_strobe_if ifb ();

    decoder_2x4_strobe #(.HOLD(4), .GAP(1)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    decoder_2x4_strobe #(.HOLD(1), .GAP(0)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each pattern of instance A at its done cycle; also verify
    // the output is never more than one-hot.
    always @(negedge clk) begin
        if (ifa.done === 1'b1) capq.push_back(ifa.out_onehot);
        total++;
        assert ($countones(ifa.out_onehot) <= 1 && !$isunknown(ifa.out_onehot))
        else begin
            bad++;
            $error("FAIL onehot_legal observed=%b expected=at most one bit", ifa.out_onehot);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle_a(input string tag);
        int n;
        n = 0;
        while (ifa.busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, ifa.busy}, 8'd0);
    endtask

    task automatic wait_ready_a(input string tag);
        int n;
        n = 0;
        while (ifa.in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, ifa.in_ready}, 8'd1);
    endtask

    // Behaviour of the upstream 4x2 encoder.
    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] c;
        c = 2'd0;
        case (oh)
            4'b0001: c = 2'd3;
            4'b0010: c = 2'd2;
            4'b0100: c = 2'd1;
            4'b1000: c = 2'd0;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    logic [1:0] bcode [6];
    logic [3:0] bexp  [6];
    logic [3:0] orig  [4];

    initial begin
        total = 0;
        bad   = 0;
        bcode = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bexp  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        orig  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst_n        = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_code  = 2'd0;
        ifb.in_valid = 1'b0;
        ifb.in_code  = 2'd0;
        #12;
        chk("rst_ready",  {7'd0, ifa.in_ready}, 8'd1);
        chk("rst_onehot", {4'd0, ifa.out_onehot}, 8'd0);
        chk("rst_valid",  {7'd0, ifa.out_valid}, 8'd0);
        chk("rst_done",   {7'd0, ifa.done}, 8'd0);
        chk("rst_busy",   {7'd0, ifa.busy}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single code 2: four cycles of 0010, done in the fourth, one blank.
        ifa.in_valid = 1'b1;
        ifa.in_code  = 2'd2;
        tick();
        ifa.in_valid = 1'b0;
        chk("t1_accept_onehot", {4'd0, ifa.out_onehot}, 8'd0);
        chk("t1_accept_busy",   {7'd0, ifa.busy}, 8'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_show%0d_onehot", i), {4'd0, ifa.out_onehot}, 8'h02);
            chk($sformatf("t1_show%0d_valid", i),  {7'd0, ifa.out_valid}, 8'd1);
            chk($sformatf("t1_show%0d_done", i),   {7'd0, ifa.done}, (i == 3) ? 8'd1 : 8'd0);
            tick();
        end
        chk("t1_gap_onehot", {4'd0, ifa.out_onehot}, 8'd0);
        chk("t1_gap_valid",  {7'd0, ifa.out_valid}, 8'd0);
        chk("t1_gap_busy",   {7'd0, ifa.busy}, 8'd1);
        tick();
        chk("t1_idle_busy",  {7'd0, ifa.busy}, 8'd0);
        chk("t1_idle_ready", {7'd0, ifa.in_ready}, 8'd1);

        // Stream 3,2,1,0: FIFO fills, full-with-pop keeps in_ready low.
        capq.delete();
        ifa.in_valid = 1'b1;
        ifa.in_code  = 2'd3;
        tick();
        chk("t2_f0_ready", {7'd0, ifa.in_ready}, 8'd1);
        ifa.in_code = 2'd2;
        tick();
        chk("t2_f1_onehot", {4'd0, ifa.out_onehot}, 8'h01);
        chk("t2_f1_ready",  {7'd0, ifa.in_ready}, 8'd1);
        ifa.in_code = 2'd1;
        tick();
        chk("t2_f2_full", {7'd0, ifa.in_ready}, 8'd0);
        ifa.in_code = 2'd0;
        tick();
        chk("t2_f3_full", {7'd0, ifa.in_ready}, 8'd0);
        tick();
        chk("t2_f4_done",  {7'd0, ifa.done}, 8'd1);
        chk("t2_f4_ready", {7'd0, ifa.in_ready}, 8'd0);
        tick();
        chk("t2_full_pop_ready",  {7'd0, ifa.in_ready}, 8'd0);
        chk("t2_full_pop_onehot", {4'd0, ifa.out_onehot}, 8'd0);
        tick();
        chk("t2_after_pop_ready",  {7'd0, ifa.in_ready}, 8'd1);
        chk("t2_after_pop_onehot", {4'd0, ifa.out_onehot}, 8'h02);
        tick();
        ifa.in_valid = 1'b0;
        chk("t2_refill_ready", {7'd0, ifa.in_ready}, 8'd0);
        wait_idle_a("t2_idle_wait");
        chk("t2_count", 8'(capq.size()), 8'd4);
        chk("t2_pat0", {4'd0, capq[0]}, 8'h01);
        chk("t2_pat1", {4'd0, capq[1]}, 8'h02);
        chk("t2_pat2", {4'd0, capq[2]}, 8'h04);
        chk("t2_pat3", {4'd0, capq[3]}, 8'h08);

        // HOLD=1, GAP=0: one new pattern per cycle, done every cycle.
        for (int k = 0; k < 6; k++) begin
            ifb.in_valid = 1'b1;
            ifb.in_code  = bcode[k];
            tick();
            chk($sformatf("t3_g%0d_ready", k), {7'd0, ifb.in_ready}, 8'd1);
            if (k >= 1) begin
                chk($sformatf("t3_g%0d_onehot", k), {4'd0, ifb.out_onehot}, {4'd0, bexp[k-1]});
                chk($sformatf("t3_g%0d_valid", k),  {7'd0, ifb.out_valid}, 8'd1);
                chk($sformatf("t3_g%0d_done", k),   {7'd0, ifb.done}, 8'd1);
            end
        end
        ifb.in_valid = 1'b0;
        tick();
        chk("t3_last_onehot", {4'd0, ifb.out_onehot}, 8'h04);
        chk("t3_last_done",   {7'd0, ifb.done}, 8'd1);
        tick();
        chk("t3_end_onehot", {4'd0, ifb.out_onehot}, 8'd0);
        chk("t3_end_valid",  {7'd0, ifb.out_valid}, 8'd0);
        chk("t3_end_busy",   {7'd0, ifb.busy}, 8'd0);

        // Asynchronous reset mid-SHOW with two codes queued.
        ifa.in_valid = 1'b1;
        ifa.in_code  = 2'd1;
        tick();
        ifa.in_code = 2'd2;
        tick();
        ifa.in_code = 2'd3;
        tick();
        chk("t4_pre_onehot", {4'd0, ifa.out_onehot}, 8'h04);
        chk("t4_pre_full",   {7'd0, ifa.in_ready}, 8'd0);
        #2;
        rst_n        = 1'b0;
        ifa.in_valid = 1'b0;
        #1;
        chk("t4_rst_onehot", {4'd0, ifa.out_onehot}, 8'd0);
        chk("t4_rst_valid",  {7'd0, ifa.out_valid}, 8'd0);
        chk("t4_rst_busy",   {7'd0, ifa.busy}, 8'd0);
        chk("t4_rst_ready",  {7'd0, ifa.in_ready}, 8'd1);
        tick();
        capq.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("t4_no_ghost", 8'(capq.size()), 8'd0);
        chk("t4_busy",     {7'd0, ifa.busy}, 8'd0);

        // Round trip: encoder output decoded back to the original one-hot.
        capq.delete();
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_code  = enc(orig[i]);
            wait_ready_a($sformatf("t5_ready%0d", i));
            tick();
        end
        ifa.in_valid = 1'b0;
        wait_idle_a("t5_idle_wait");
        chk("t5_count", 8'(capq.size()), 8'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_rt%0d", i), {4'd0, capq[i]}, {4'd0, orig[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
